dir_pulse_gen: RTL and testbench

- Upstream conditioner for the ball position controller. Converts four raw, bouncy pushbutton levels (btnU/btnD/btnL/btnR) into registered single-cycle move strobes `up`/`down`/`left`/`right`.
- The position controller steps once per clock while its inputs are high, so this block limits movement to one step per strobe.
- Holding a button gives one immediate strobe, then auto-repeat after a delay.
- All strobes come from one shared timer, so diagonal pairs (up+left etc.) always strobe in the same cycle.

---
 rtl/dir_pulse_gen_if.sv | 23 ++
 rtl/dir_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_dir_pulse_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dir_pulse_gen_if.sv
// Pushbutton-to-strobe bundle: raw button levels in, move strobes and debounced levels out.
// The button source (board or bench) is the master; dir_pulse_gen is the slave.
interface dir_pulse_gen_if;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] held;

    modport master (
        output btnU, btnD, btnL, btnR,
        input  up, down, left, right, held
    );

    modport slave (
        input  btnU, btnD, btnL, btnR,
        output up, down, left, right, held
    );
endinterface

// File: rtl/dir_pulse_gen.sv
// Debounces four raw pushbuttons and turns them into single-cycle move strobes with
// auto-repeat, all driven from one shared timer so diagonals always strobe together.
module dir_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    dir_pulse_gen_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Bit order throughout is {U, D, L, R}.
    logic [3:0]      raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      stable;
    logic [DB_W-1:0] db_cnt [4];

    assign raw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the 2-FF synchronizer into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            // NOTE: the per-button counters are a small register array, not RAM, so they
            // can and must be cleared in reset like any other flop.
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Opposite directions cancel each other out rather than picking a winner.
    logic [3:0] mask;

    always_comb begin
        mask = stable;
        if (stable[3] && stable[2]) mask[3:2] = 2'b00;
        if (stable[1] && stable[0]) mask[1:0] = 2'b00;
    end

    state_t           state_q;
    state_t           state_d;
    logic [RPT_W-1:0] cnt_q;
    logic [RPT_W-1:0] cnt_d;
    logic [3:0]       prev_mask_q;
    logic [3:0]       strobe_q;
    logic [3:0]       strobe_d;
    logic             fire;
    logic             gained;

    assign gained = |(mask & ~prev_mask_q);

    // NOTE: every signal written in this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mask != 4'b0000) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (mask == 4'b0000) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (gained) begin
                    fire  = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (mask == 4'b0000) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (gained) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end else if (cnt_q == PERIOD_LAST) begin
                    fire  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + RPT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        strobe_d = fire ? mask : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_mask_q <= '0;
            strobe_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_mask_q <= mask;
            strobe_q    <= strobe_d;
        end
    end

    assign bus.up    = strobe_q[3];
    assign bus.down  = strobe_q[2];
    assign bus.left  = strobe_q[1];
    assign bus.right = strobe_q[0];
    assign bus.held  = stable;

endmodule

// File: tb/tb_dir_pulse_gen.sv
// Scoreboard bench for dir_pulse_gen: each scenario queues the strobes it expects
// (cycle and {U,D,L,R} vector) and a negedge monitor pops and compares them.
module tb_dir_pulse_gen;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = DB + 3;

    localparam logic [3:0] V_U  = 4'b1000;
    localparam logic [3:0] V_D  = 4'b0100;
    localparam logic [3:0] V_L  = 4'b0010;
    localparam logic [3:0] V_R  = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    dir_pulse_gen_if bus ();

    dir_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every nonzero strobe vector must match the head of the scoreboard.
    logic [3:0] prev_vec = 4'b0000;
    always @(negedge clk) begin
        logic [3:0] vec;
        exp_t       e;
        vec = {bus.up, bus.down, bus.left, bus.right};
        if (vec != 4'b0000) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d got=%b expected none", cyc, vec);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc !== cyc || e.vec !== vec) begin
                    errors++;
                    $display("FAIL strobe got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                             cyc, vec, e.cyc, e.vec);
                end
            end
            if (prev_vec != 4'b0000) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b after=%b expected gap", cyc, vec, prev_vec);
            end
            if ((vec[3] && vec[2]) || (vec[1] && vec[0])) begin
                errors++;
                $display("FAIL opposite cyc=%0d got=%b expected no opposing pair", cyc, vec);
            end
        end
        prev_vec = vec;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected finish before time limit", cyc);
        $fatal(1, "watchdog");
    end

    task automatic run_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input int t, input logic [3:0] v);
        exp_t e;
        e.cyc = t;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    // Strobe schedule for a clean press at cycle c released at cycle r.
    task automatic push_hold(input int c, input int r, input logic [3:0] v);
        int t;
        t = c + LAT;
        push(t, v);
        t += RD;
        while (t <= r + LAT - 1) begin
            push(t, v);
            t += RP;
        end
    endtask

    task automatic check_held(input string name, input logic [3:0] exp);
        checks++;
        if (bus.held !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d held=%b expected %b", name, cyc, bus.held, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        logic [3:0] vec;
        vec = {bus.up, bus.down, bus.left, bus.right};
        checks++;
        if (vec !== 4'b0000) begin
            errors++;
            $display("FAIL %s cyc=%0d strobes=%b expected 0000", name, cyc, vec);
        end
    endtask

    task automatic drain(input string name);
        run_to(cyc + 20);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing cyc=%0d pending=%0d first_cyc=%0d expected 0 pending",
                     name, cyc, sb_q.size(), sb_q[0].cyc);
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        bus.btnU = 1'b1;
        run_to(cyc + 2);
        check_held("reset_held", 4'b0000);
        check_quiet("reset_strobes");
        c = cyc;
        rst = 1'b0;
        push(c + LAT, V_U);
        run_to(c + LAT - 2);
        check_held("reset_held_before_flip", 4'b0000);
        run_to(c + LAT - 1);
        check_held("reset_held_after_flip", V_U);
        run_to(c + 9);
        bus.btnU = 1'b0;
        drain("reset");
    endtask

    task automatic test_bounce();
        int c;
        c = cyc;
        bus.btnL = 1'b1;
        run_to(c + 2); bus.btnL = 1'b0;
        run_to(c + 4); bus.btnL = 1'b1;
        run_to(c + 6); bus.btnL = 1'b0;
        run_to(c + 8); bus.btnL = 1'b1;
        push(c + 8 + LAT, V_L);
        run_to(c + 13);
        check_held("bounce_no_early_flip", 4'b0000);
        run_to(c + 17);
        bus.btnL = 1'b0;
        drain("bounce");
    endtask

    task automatic test_hold_repeat();
        int c;
        c = cyc;
        bus.btnR = 1'b1;
        push_hold(c, c + 40, V_R);
        run_to(c + 40);
        bus.btnR = 1'b0;
        drain("hold_repeat");
    endtask

    task automatic test_diagonal();
        int c;
        c = cyc;
        bus.btnU = 1'b1;
        bus.btnL = 1'b1;
        push_hold(c, c + 30, V_U | V_L);
        run_to(c + 30);
        bus.btnU = 1'b0;
        bus.btnL = 1'b0;
        drain("diagonal");
    endtask

    task automatic test_add_remove();
        int c;
        c = cyc;
        bus.btnU = 1'b1;
        push(c + 7,  V_U);
        push(c + 17, V_U);
        push(c + 20, V_U);
        push(c + 23, V_U);
        push(c + 26, V_U);
        push(c + 28, V_U | V_R);
        push(c + 38, V_U | V_R);
        push(c + 41, V_U | V_R);
        push(c + 44, V_U | V_R);
        push(c + 47, V_U);
        push(c + 50, V_U);
        push(c + 53, V_U);
        push(c + 56, V_U);
        push(c + 59, V_U);
        run_to(c + 21);
        bus.btnR = 1'b1;
        run_to(c + 40);
        bus.btnR = 1'b0;
        run_to(c + 55);
        bus.btnU = 1'b0;
        drain("add_remove");
    endtask

    task automatic test_conflict();
        int c;
        c = cyc;
        bus.btnU = 1'b1;
        bus.btnD = 1'b1;
        run_to(c + 10);
        check_held("conflict_held", V_U | V_D);
        run_to(c + 15);
        bus.btnD = 1'b0;
        push(c + 15 + LAT, V_U);
        run_to(c + 25);
        bus.btnU = 1'b0;
        drain("conflict");
    endtask

    task automatic test_reset_abort();
        int c;
        c = cyc;
        bus.btnR = 1'b1;
        push(c + LAT, V_R);
        run_to(c + 16);
        rst = 1'b1;
        run_to(c + 17);
        check_quiet("abort_strobes");
        check_held("abort_held", 4'b0000);
        rst = 1'b0;
        push(c + 17 + LAT, V_R);
        run_to(c + 26);
        bus.btnR = 1'b0;
        drain("reset_abort");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.btnU = 1'b0;
        bus.btnD = 1'b0;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        @(negedge clk);
        test_reset();
        test_bounce();
        test_hold_repeat();
        test_diagonal();
        test_add_remove();
        test_conflict();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
